// File: rtl/mem_arb_pkg.sv
// Shared definitions for the byte-wide memory arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    // Request length codes; 2'b11 is folded onto the 4-byte case.
    localparam logic [1:0] LEN_1B = 2'b00;
    localparam logic [1:0] LEN_2B = 2'b01;
    localparam logic [1:0] LEN_4B = 2'b10;

    // IO region: address bits [17:16] == 2'b11.
    localparam int         IO_MSB = 17;
    localparam int         IO_LSB = 16;
    localparam logic [1:0] IO_TAG = 2'b11;

    // Address driven whenever no byte is being issued.
    localparam logic [31:0] SAFE_ADDR = 32'h0000_0000;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_1B:  return 3'd1;
            LEN_2B:  return 3'd2;
            LEN_4B:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/arb_select.sv
// Picks one requester: fixed priority (highest index) or round-robin after ptr.
// Latency: purely combinational, no state.
// Backpressure: none; masked requesters are treated as not requesting.
// Ports: req/mask per channel in, ptr = last granted channel (round-robin only),
//        gnt one-hot winner, idx its index, any = a winner exists.
module arb_select #(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 0,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    logic [NUM_CH-1:0] elig;

    assign elig = req & ~mask;

    always_comb begin
        int c;
        c   = 0;
        idx = '0;
        any = 1'b0;
        if (ARB_MODE == 0) begin
            // Ascending scan: the last hit is the highest index.
            for (int i = 0; i < NUM_CH; i++) begin
                if (elig[i]) begin
                    idx = CH_W'(i);
                    any = 1'b1;
                end
            end
        end else begin
            // Walk the search order backwards so the last hit is ptr+1 first.
            for (int k = NUM_CH; k >= 1; k--) begin
                c = (int'(ptr) + k) % NUM_CH;
                if (elig[c]) begin
                    idx = CH_W'(c);
                    any = 1'b1;
                end
            end
        end
        gnt = '0;
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH requesters onto a byte-wide RAM/IO bus, serialising 1/2/4-byte LE transfers.
// Latency: read response at grant+L+2, write response at grant+L+1 (L = byte count), rdy pauses add cycles.
// Backpressure: req_ready only in IDLE with rdy high; rdy low freezes issue and forces mem_a/mem_wr to 0.
// Ports: clk, rst_n (async, active-low), rdy; per-channel req_valid/req_we/req_len/req_addr/req_wdata/flush,
//        req_ready/resp_valid out, shared resp_rdata; bus mem_din in, mem_dout/mem_a/mem_wr out.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [2*NUM_CH-1:0]      req_len,
    input  logic [ADDR_W*NUM_CH-1:0] req_addr,
    input  logic [32*NUM_CH-1:0]     req_wdata,
    input  logic [NUM_CH-1:0]        flush,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [31:0]              resp_rdata,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [31:0]              mem_a,
    output logic                     mem_wr
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t              state;
    logic [CH_W-1:0]     ch_q;
    logic [CH_W-1:0]     rr_ptr;
    logic [2:0]          len_q;
    logic [2:0]          iss;       // bytes already put on the bus
    logic [2:0]          cap;       // bytes already captured from mem_din
    logic                cap_pend;  // mem_din this cycle belongs to lane cap
    logic                we_q;
    logic                io_q;
    logic                bus_vld;   // cur_addr holds a byte still to be issued
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         wdata_q;
    logic [31:0]         rd_buf;
    logic [31:0]         resp_rdata_q;
    logic [7:0]          dout_q;
    logic [NUM_CH-1:0]   resp_vld_q;

    logic [NUM_CH-1:0]   win_oh;
    logic [CH_W-1:0]     win_idx;
    logic                win_any;
    logic                gnt_vld;

    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          sel_len;
    logic                sel_we;
    logic [31:0]         sel_wdata;

    logic                iss_fire;
    logic                iss_last;
    logic [2:0]          iss_n;
    logic [2:0]          cap_nxt;
    logic [31:0]         rd_merge;

    arb_select #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE),
        .CH_W     (CH_W)
    ) u_sel (
        .req  (req_valid),
        .mask (flush),
        .ptr  (rr_ptr),
        .gnt  (win_oh),
        .idx  (win_idx),
        .any  (win_any)
    );

    assign gnt_vld   = (state == ST_IDLE) && rdy && win_any;
    assign req_ready = gnt_vld ? win_oh : '0;

    assign sel_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign sel_len   = req_len[win_idx*2 +: 2];
    assign sel_we    = req_we[win_idx];
    assign sel_wdata = req_wdata[win_idx*32 +: 32];

    assign iss_fire  = rdy && bus_vld;
    assign iss_n     = iss + 3'd1;
    assign iss_last  = (iss_n == len_q);
    assign cap_nxt   = cap + {2'b00, cap_pend};

    // Read data including the byte arriving this cycle, so completion can
    // register the full word on the same edge that captures the last lane.
    always_comb begin
        rd_merge = rd_buf;
        if (cap_pend) begin
            rd_merge[{cap[1:0], 3'b000} +: 8] = mem_din;
        end
    end

    // Registered bus state; rdy low only masks it, it never alters it.
    assign mem_a      = iss_fire ? 32'(cur_addr) : SAFE_ADDR;
    assign mem_wr     = iss_fire && we_q;
    assign mem_dout   = dout_q;
    assign resp_valid = resp_vld_q;
    assign resp_rdata = resp_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ch_q         <= '0;
            rr_ptr       <= CH_W'(NUM_CH - 1);
            len_q        <= 3'd0;
            iss          <= 3'd0;
            cap          <= 3'd0;
            cap_pend     <= 1'b0;
            we_q         <= 1'b0;
            io_q         <= 1'b0;
            bus_vld      <= 1'b0;
            cur_addr     <= '0;
            wdata_q      <= 32'h0;
            rd_buf       <= 32'h0;
            resp_rdata_q <= 32'h0;
            dout_q       <= 8'h00;
            resp_vld_q   <= '0;
        end else begin
            resp_vld_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        ch_q     <= win_idx;
                        rr_ptr   <= win_idx;
                        len_q    <= len_bytes(sel_len);
                        we_q     <= sel_we;
                        io_q     <= (sel_addr[IO_MSB:IO_LSB] == IO_TAG);
                        cur_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        dout_q   <= sel_we ? sel_wdata[7:0] : 8'h00;
                        bus_vld  <= 1'b1;
                        iss      <= 3'd0;
                        cap      <= 3'd0;
                        cap_pend <= 1'b0;
                        rd_buf   <= 32'h0;
                        state    <= sel_we ? ST_WR : ST_RD;
                    end
                end

                ST_RD: begin
                    // Drain a byte issued last cycle even while paused.
                    if (cap_pend) begin
                        rd_buf <= rd_merge;
                        cap    <= cap + 3'd1;
                    end
                    cap_pend <= iss_fire;
                    if (iss_fire) begin
                        iss <= iss_n;
                        if (iss_last) begin
                            bus_vld <= 1'b0;
                        end else begin
                            cur_addr <= cur_addr + ADDR_W'(1);
                        end
                    end
                    if (flush[ch_q] && !io_q) begin
                        // Speculative read abandoned; in-flight bytes are dropped.
                        state    <= ST_IDLE;
                        bus_vld  <= 1'b0;
                        cap_pend <= 1'b0;
                    end else if (rdy && (cap_nxt == len_q)) begin
                        state          <= ST_IDLE;
                        cap_pend       <= 1'b0;
                        resp_vld_q[ch_q] <= 1'b1;
                        resp_rdata_q   <= rd_merge;
                    end
                end

                ST_WR: begin
                    if (iss_fire) begin
                        iss <= iss_n;
                        if (iss_last) begin
                            bus_vld          <= 1'b0;
                            dout_q           <= 8'h00;
                            state            <= ST_IDLE;
                            resp_vld_q[ch_q] <= 1'b1;
                        end else begin
                            cur_addr <= cur_addr + ADDR_W'(1);
                            dout_q   <= wdata_q[{iss_n[1:0], 3'b000} +: 8];
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    bus_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-priority 2-channel instance plus a 3-channel round-robin instance.
// Latency: n/a.
// Backpressure: rdy and flush are driven by the stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;

    logic [1:0]  req_valid, req_we, flush, req_ready, resp_valid;
    logic [3:0]  req_len;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] resp_rdata, mem_a;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_wr;

    logic [2:0]  rr_req_valid, rr_req_we, rr_flush, rr_req_ready, rr_resp_valid;
    logic [5:0]  rr_req_len;
    logic [95:0] rr_req_addr, rr_req_wdata;
    logic [31:0] rr_resp_rdata, rr_mem_a;
    logic [7:0]  rr_mem_din, rr_mem_dout;
    logic        rr_mem_wr;

    logic [7:0]  ram [0:1023];

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    // RAM with 2-cycle read latency: address seen in cycle t, byte sampled by the DUT at the end of t+1.
    always @(posedge clk) mem_din <= ram[mem_a[9:0]];

    mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .req_valid(req_valid), .req_we(req_we), .req_len(req_len),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_arbiter #(.NUM_CH(3), .ADDR_W(32), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .req_valid(rr_req_valid), .req_we(rr_req_we), .req_len(rr_req_len),
        .req_addr(rr_req_addr), .req_wdata(rr_req_wdata), .flush(rr_flush),
        .req_ready(rr_req_ready), .resp_valid(rr_resp_valid), .resp_rdata(rr_resp_rdata),
        .mem_din(rr_mem_din), .mem_dout(rr_mem_dout), .mem_a(rr_mem_a), .mem_wr(rr_mem_wr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hits;
        int bad;
        int n_g;
        int n_rsp;
        logic [2:0]  gseq [0:3];
        logic [31:0] exp_a [1:9];

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05;
        ram[10'h200] = 8'h77; ram[10'h201] = 8'h66;
        ram[10'h300] = 8'hA1; ram[10'h301] = 8'hB2; ram[10'h302] = 8'hC3; ram[10'h303] = 8'hD4;

        rst_n = 1'b0; rdy = 1'b1;
        req_valid = '0; req_we = '0; req_len = '0; req_addr = '0; req_wdata = '0; flush = '0;
        rr_req_valid = '0; rr_req_we = '0; rr_req_len = '0; rr_req_addr = '0; rr_req_wdata = '0;
        rr_flush = '0; rr_mem_din = 8'h00;

        // Reset values
        #12;
        check_eq("rst_mem_a", mem_a, 32'h0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'h0);
        check_eq("rst_mem_dout", 32'(mem_dout), 32'h0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_eq("rst_resp_rdata", resp_rdata, 32'h0);
        step; rst_n = 1'b1;
        step;

        // Round-robin: all three channels write 1 byte continuously.
        rr_req_valid = 3'b111; rr_req_we = 3'b111; rr_req_len = 6'b000000;
        rr_req_addr  = {32'h0003_0000, 32'h0003_0000, 32'h0003_0000};
        rr_req_wdata = {32'h33, 32'h22, 32'h11};
        n_g = 0; n_rsp = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 7) rr_req_valid = 3'b000;
            samp;
            if (rr_req_ready != 3'b000 && n_g < 4) begin
                gseq[n_g] = rr_req_ready;
                n_g++;
            end
            if (rr_resp_valid != 3'b000) n_rsp++;
            step;
        end
        check_eq("rr_grant_count", 32'(n_g), 32'd4);
        check_eq("rr_grant0", 32'(gseq[0]), 32'b001);
        check_eq("rr_grant1", 32'(gseq[1]), 32'b010);
        check_eq("rr_grant2", 32'(gseq[2]), 32'b100);
        check_eq("rr_grant3", 32'(gseq[3]), 32'b001);
        check_eq("rr_resp_count", 32'(n_rsp), 32'd4);
        check_eq("rr_idle_a", rr_mem_a, 32'h0);
        check_eq("rr_idle_wr", 32'(rr_mem_wr), 32'h0);
        check_eq("rr_idle_dout", 32'(rr_mem_dout), 32'h0);
        check_eq("rr_rdata", rr_resp_rdata, 32'h0);

        // ch0 4-byte read at 0x100
        req_valid = 2'b01; req_we = 2'b00; req_len = 4'b0010; req_addr = {32'h0, 32'h0000_0100};
        samp; check_eq("rd4_gnt", 32'(req_ready), 32'b01);
        for (int k = 0; k < 4; k++) begin
            step; req_valid = 2'b00;
            samp;
            check_eq($sformatf("rd4_a%0d", k), mem_a, 32'h100 + 32'(k));
            check_eq($sformatf("rd4_novld%0d", k), 32'(resp_valid), 32'h0);
        end
        step; samp; check_eq("rd4_a_idle", mem_a, 32'h0);
        check_eq("rd4_novld5", 32'(resp_valid), 32'h0);
        step; samp;
        check_eq("rd4_resp", 32'(resp_valid), 32'b01);
        check_eq("rd4_rdata", resp_rdata, 32'h0000_0513);
        step; samp; check_eq("rd4_pulse_end", 32'(resp_valid), 32'h0);

        // ch1 1-byte write of 0x41 to 0x30000
        step;
        req_valid = 2'b10; req_we = 2'b10; req_len = 4'b0000;
        req_addr = {32'h0003_0000, 32'h0}; req_wdata = {32'h41, 32'h0};
        samp; check_eq("wr1_gnt", 32'(req_ready), 32'b10);
        step; req_valid = 2'b00;
        samp;
        check_eq("wr1_wr", 32'(mem_wr), 32'h1);
        check_eq("wr1_a", mem_a, 32'h0003_0000);
        check_eq("wr1_dout", 32'(mem_dout), 32'h41);
        step; samp;
        check_eq("wr1_resp", 32'(resp_valid), 32'b10);
        check_eq("wr1_wr_off", 32'(mem_wr), 32'h0);
        check_eq("wr1_a_idle", mem_a, 32'h0);

        // Fixed priority: ch1 (1-byte write) beats ch0 (1-byte read); ch0 granted in ch1's resp cycle.
        step;
        req_valid = 2'b11; req_we = 2'b10; req_len = 4'b0000;
        req_addr = {32'h0003_0004, 32'h0000_0100}; req_wdata = {32'h5A, 32'h0};
        samp; check_eq("fp_gnt_ch1", 32'(req_ready), 32'b10);
        step; req_valid = 2'b01;
        samp; check_eq("fp_busy", 32'(req_ready), 32'b00);
        step; samp;
        check_eq("fp_resp_ch1", 32'(resp_valid), 32'b10);
        check_eq("fp_gnt_ch0", 32'(req_ready), 32'b01);
        step; req_valid = 2'b00;
        samp; check_eq("fp_rd_a", mem_a, 32'h100);
        step; samp; check_eq("fp_rd_wait", 32'(resp_valid), 32'h0);
        step; samp;
        check_eq("fp_resp_ch0", 32'(resp_valid), 32'b01);
        check_eq("fp_rdata_ch0", resp_rdata, 32'h13);

        // Flush of a RAM read at 0x200 in G+2: aborted, bus idle, no response.
        step;
        req_valid = 2'b01; req_we = 2'b00; req_len = 4'b0010; req_addr = {32'h0, 32'h0000_0200};
        samp; check_eq("fl_gnt", 32'(req_ready), 32'b01);
        step; req_valid = 2'b00;
        samp; check_eq("fl_a0", mem_a, 32'h200);
        step; flush = 2'b01;
        samp; check_eq("fl_a1", mem_a, 32'h201);
        hits = 0; bad = 0;
        for (int k = 0; k < 6; k++) begin
            step; flush = 2'b00;
            samp;
            if (mem_a != 32'h0) bad++;
            if (resp_valid[0]) hits++;
        end
        check_eq("fl_bus_idle", 32'(bad), 32'd0);
        check_eq("fl_no_resp", 32'(hits), 32'd0);

        // Same flush against an IO read at 0x30000 is ignored.
        step;
        req_valid = 2'b01; req_len = 4'b0010; req_addr = {32'h0, 32'h0003_0000};
        samp; check_eq("io_gnt", 32'(req_ready), 32'b01);
        hits = 0;
        for (int k = 1; k <= 6; k++) begin
            step; req_valid = 2'b00;
            flush = (k == 2) ? 2'b01 : 2'b00;
            samp;
            if (k == 6) begin
                check_eq("io_resp", 32'(resp_valid), 32'b01);
                check_eq("io_rdata", resp_rdata, 32'h4433_2211);
            end else if (resp_valid != 2'b00) hits++;
        end
        check_eq("io_no_early_resp", 32'(hits), 32'd0);

        // Flush masks a same-channel request in IDLE; rdy low blocks all grants.
        step;
        req_valid = 2'b01; flush = 2'b01;
        samp; check_eq("mask_flush", 32'(req_ready), 32'b00);
        rdy = 1'b0; flush = 2'b00;
        #1; check_eq("pause_no_gnt", 32'(req_ready), 32'b00);
        req_valid = 2'b00;
        step; rdy = 1'b1;

        // ch1 4-byte read at 0x300 with rdy low for G+2..G+4.
        req_valid = 2'b10; req_we = 2'b00; req_len = 4'b1000; req_addr = {32'h0000_0300, 32'h0};
        samp; check_eq("ps_gnt", 32'(req_ready), 32'b10);
        exp_a[1] = 32'h300; exp_a[2] = 32'h0; exp_a[3] = 32'h0; exp_a[4] = 32'h0;
        exp_a[5] = 32'h301; exp_a[6] = 32'h302; exp_a[7] = 32'h303; exp_a[8] = 32'h0; exp_a[9] = 32'h0;
        hits = 0;
        for (int k = 1; k <= 9; k++) begin
            step; req_valid = 2'b00;
            rdy = !(k >= 2 && k <= 4);
            samp;
            check_eq($sformatf("ps_a%0d", k), mem_a, exp_a[k]);
            if (k == 9) begin
                check_eq("ps_resp", 32'(resp_valid), 32'b10);
                check_eq("ps_rdata", resp_rdata, 32'hD4C3_B2A1);
            end else if (resp_valid != 2'b00) hits++;
        end
        check_eq("ps_no_early_resp", 32'(hits), 32'd0);

        // Reset asserted at G+2 of a 4-byte write.
        step;
        req_valid = 2'b01; req_we = 2'b01; req_len = 4'b0010;
        req_addr = {32'h0, 32'h0000_0400}; req_wdata = {32'h0, 32'hDDCC_BBAA};
        samp; check_eq("rw_gnt", 32'(req_ready), 32'b01);
        step; req_valid = 2'b00;
        samp;
        check_eq("rw_wr0", 32'(mem_wr), 32'h1);
        check_eq("rw_dout0", 32'(mem_dout), 32'hAA);
        step;
        rst_n = 1'b0;
        #1;
        check_eq("rw_async_wr", 32'(mem_wr), 32'h0);
        check_eq("rw_async_a", mem_a, 32'h0);
        check_eq("rw_async_dout", 32'(mem_dout), 32'h0);
        step; step; rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            samp;
            if (mem_wr || resp_valid != 2'b00 || mem_a != 32'h0) bad++;
            step;
        end
        check_eq("rw_quiet_after_rst", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised multi-channel memory controller.
- Arbitrates NUM_CH requesters (instruction fetch, load/store, future cache refill) onto the single byte-wide RAM/IO bus of the RV32I core.
- Serialises 1/2/4-byte little-endian transfers and pipelines reads against the 2-cycle RAM read latency.
- Supports per-channel abort of speculative reads, fixed-priority or round-robin arbitration, and a pause input.
- Sits between the pipeline's IF/MEM stages and the external mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- NUM_CH, 2, number of requester channels (>=1); channel index 0 = instruction fetch.
- ADDR_W, 32, address width.
- ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; low = pause.
- req_valid  in  NUM_CH  per-channel request.
- req_we  in  NUM_CH  1 = write.
- req_len  in  2*NUM_CH  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = treated as 4.
- req_addr  in  ADDR_W*NUM_CH  byte address of byte 0.
- req_wdata  in  32*NUM_CH  write data, little-endian.
- flush  in  NUM_CH  abort this channel's pending/in-flight read.
- req_ready  out  NUM_CH  one-hot grant, combinational, IDLE only.
- resp_valid  out  NUM_CH  one-cycle completion pulse.
- resp_rdata  out  32  shared read data, zero-extended.
- mem_din  in  8  RAM/IO read byte.
- mem_dout  out  8  RAM/IO write byte.
- mem_a  out  32  bus address.
- mem_wr  out  1  1 = write.

Behaviour:
- Reset: state IDLE; mem_a = 0, mem_dout = 0, mem_wr = 0, resp_valid = 0, resp_rdata = 0; round-robin pointer points at channel NUM_CH-1, so channel 0 is searched first.
- States: IDLE, RD, WR. All bus outputs are registered.
- IDLE:
  - Winner = requesting channel whose flush is low, selected per ARB_MODE.
  - req_ready[winner] = 1 in that cycle (grant cycle G). Addr, len, we and wdata are latched on the edge ending G.
  - With no winner, mem_a = 0 and mem_wr = 0. Address 0 is the safe idle address; IO addresses are never left on the bus.
- RD:
  - Byte k address presented in cycle G+1+k.
  - mem_din sampled in cycle G+2+k into lane k.
  - resp_valid[ch] and resp_rdata are valid in cycle G+L+2, where L = byte count.
  - The state is IDLE in that same cycle, so a new grant can occur there.
- WR:
  - Byte k presented with mem_wr = 1 and mem_dout = wdata[8k+7:8k] in cycle G+1+k.
  - resp_valid in cycle G+L+1; back in IDLE in that cycle.
- Address increments addr+k with full ADDR_W wrap. Unaligned addresses are allowed.
- IO region: mem_a[17:16] == 2'b11.
  - IO reads and all writes are non-abortable; flush is ignored for them.
- Flush during RD to a non-IO address of the flushed channel:
  - Return to IDLE on the next edge.
  - No resp_valid; mem_a = 0 from the next cycle.
- Flush with req_valid on the same channel in IDLE: that channel is not granted this cycle.
- rdy low:
  - State, counters and the RR pointer are frozen.
  - mem_wr is forced to 0 and mem_a to 0 (combinational override).
  - A read byte whose address was presented in the previous cycle is still captured; a one-entry "pending capture" flag drains it.
  - On resume, issue continues at the next unissued byte.
  - No byte is read twice and no write byte is lost.
  - req_ready is 0 while rdy is low. resp_valid is held off until rdy is high, then pulses once.
- rst_n low mid-transaction: immediate abort to reset values; no response.
- Round-robin: the pointer updates to the winner on each grant. Search order is pointer+1 ... pointer, mod NUM_CH.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE/RD/WR);
  - length codes and a len-to-bytecount function;
  - IO region constant (bits 17:16 == 2'b11);
  - safe idle address 0.
- One sub-module: arb_select (parameters NUM_CH, ARB_MODE). Inputs request, mask and pointer; outputs one-hot winner and its index. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- ch0 reads 4 bytes at 0x00000100 (RAM bytes 0x13,0x05,0x00,0x00) -> mem_a = 0x100..0x103 in G+1..G+4; resp_valid[0] at G+6 with resp_rdata = 0x00000513.
- ch1 writes 1 byte 0x41 to 0x00030000 -> one cycle with mem_wr = 1, mem_a = 0x30000, mem_dout = 0x41; resp_valid[1] at G+2; mem_a returns to 0.
- ch0 and ch1 request together, ARB_MODE = 0 -> ch1 granted first, ch0 granted in ch1's resp cycle. With ARB_MODE = 1 and NUM_CH = 3, all requesting continuously -> grants rotate 0, 1, 2, 0.
- ch0 4-byte read at 0x200, flush[0] pulsed in G+2 -> IDLE next edge, no resp_valid[0], mem_a = 0. Same flush on a read of 0x30000 -> ignored, resp_valid delivered.
- ch1 4-byte read, rdy low for 3 cycles starting G+2 -> each address presented exactly once with mem_a = 0 during the pause; resp_rdata is correct and resp_valid is delayed by 3 cycles.
- rst_n asserted at G+2 of a 4-byte write -> no further mem_wr; outputs take reset values asynchronously.
